// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI peripheral that oversamples SCK/CS/MOSI on clk and returns MISO.
// Frames are WIDTH bits, LSB first in both directions.
//
// Ports
//   clk, rst           system clock (rising edge), synchronous active-low reset
//   CKP, CPH           SCK idle level / active edge select (0 rising, 1 falling)
//   SCK, CS, MOSI      asynchronous SPI inputs from the master
//   MISO               registered serial data to the master
//   tx_data, tx_wr     preload word into the one-entry tx buffer (taken when tx_ready=1)
//   tx_ready           tx buffer empty
//   rx_data, rx_valid  last received word and its valid flag
//   rx_ack             consumer took rx_data
//   overrun, underrun, frame_err   single-cycle status pulses
//   busy               FSM not idle
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for CS falling edge; MISO low
// SHIFT   | frame in progress; one bit per active SCK edge
// DONE    | one cycle: publish rx_sh to rx_data, flag overrun if unread
// WAIT_CS | frame complete; ignore SCK until CS returns high

module spi_slave_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CKP,
    input  logic             CPH,
    input  logic             SCK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_wr,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             overrun,
    output logic             underrun,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2,
        WAIT_CS = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall, active_edge;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;
    assign cs_rise     = cs_s & ~cs_prev_q;
    assign cs_fall     = ~cs_s & cs_prev_q;
    assign active_edge = CPH ? sck_fall : sck_rise;

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic             tx_ready_q, tx_ready_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;
    logic             frame_err_q, frame_err_d;
    logic             miso_q, miso_d;
    logic             load;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            tx_buf_q    <= '0;
            tx_ready_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            tx_buf_q    <= tx_buf_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        tx_buf_d    = tx_buf_q;
        tx_ready_d  = tx_ready_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        load        = 1'b0;

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    rx_sh_d    = '0;
                    load       = 1'b1;
                    tx_ready_d = 1'b1;
                    if (tx_ready_q) begin
                        tx_sh_d    = '0;
                        underrun_d = 1'b1;
                    end else begin
                        tx_sh_d = tx_buf_q;
                    end
                end
            end
            SHIFT: begin
                // A completing edge wins over a simultaneous CS rise; WAIT_CS
                // looks at the CS level so the rise is not lost.
                if (active_edge && (bit_cnt_q == LAST_BIT)) begin
                    rx_sh_d   = {mosi_s, rx_sh_q[WIDTH-1:1]};
                    tx_sh_d   = tx_sh_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = DONE;
                end else if (cs_rise) begin
                    frame_err_d = 1'b1;
                    rx_sh_d     = '0;
                    state_d     = IDLE;
                end else if (active_edge) begin
                    rx_sh_d   = {mosi_s, rx_sh_q[WIDTH-1:1]};
                    tx_sh_d   = tx_sh_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            DONE: begin
                rx_data_d  = rx_sh_q;
                rx_valid_d = 1'b1;
                overrun_d  = rx_valid_q && !rx_ack;
                state_d    = WAIT_CS;
            end
            WAIT_CS: begin
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The buffer is freed by the load in the same cycle, so a write
        // coinciding with the load is accepted.
        if (tx_wr && (tx_ready_q || load)) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end

        miso_d = (state_d == SHIFT) ? tx_sh_d[0] : 1'b0;
    end

    assign MISO      = miso_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       CKP = 1'b0;
    logic       CPH = 1'b0;
    logic       SCK = 1'b0;
    logic       CS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       overrun;
    logic       underrun;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_fail = 0;
    int ovr_cnt = 0;
    int udr_cnt = 0;
    int fe_cnt = 0;

    spi_slave_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
        .MOSI(MOSI), .MISO(MISO), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ack(rx_ack), .overrun(overrun), .underrun(underrun),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (overrun)   ovr_cnt <= ovr_cnt + 1;
        if (underrun)  udr_cnt <= udr_cnt + 1;
        if (frame_err) fe_cnt  <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic ack_rx();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Master model: two SCK toggles per bit, MISO sampled just before the
    // active edge, MOSI changed while SCK sits at its idle level.
    task automatic spi_frame(input logic [7:0] w, input int nbits, input bit raise_cs,
                             output logic [7:0] r);
        logic nxt;
        r = 8'h00;
        @(negedge clk);
        SCK = CKP;
        wait_clk(6);
        CS = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[i];
            wait_clk(H);
            for (int t = 0; t < 2; t++) begin
                nxt = ~SCK;
                if (nxt == ~CPH) r[i] = MISO;
                SCK = nxt;
                wait_clk(H);
            end
        end
        if (raise_cs) begin
            CS = 1'b1;
            wait_clk(8);
        end
    endtask

    logic [7:0] r;
    int o0, u0, f0;

    initial begin
        // Reset
        rst = 1'b0;
        wait_clk(4);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_pulses", {29'd0, overrun, underrun, frame_err}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        wait_clk(6);

        // Mode 0/0 basic transfer
        u0 = udr_cnt;
        tx_write(8'hA5);
        check("m00_tx_ready_full", 32'(tx_ready), 32'd0);
        spi_frame(8'h3C, 8, 1'b1, r);
        check("m00_rx_data", 32'(rx_data), 32'h3C);
        check("m00_rx_valid", 32'(rx_valid), 32'd1);
        check("m00_miso_word", 32'(r), 32'hA5);
        check("m00_tx_ready", 32'(tx_ready), 32'd1);
        check("m00_no_underrun", 32'(udr_cnt - u0), 32'd0);
        check("m00_busy_after", 32'(busy), 32'd0);
        ack_rx();
        check("m00_ack", 32'(rx_valid), 32'd0);

        // All four modes
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            CKP = m[1];
            CPH = m[0];
            wait_clk(6);
            tx_write(8'h81);
            spi_frame(8'h7E, 8, 1'b1, r);
            check($sformatf("mode%0d_rx_data", m), 32'(rx_data), 32'h7E);
            check($sformatf("mode%0d_miso_word", m), 32'(r), 32'h81);
            check($sformatf("mode%0d_rx_valid", m), 32'(rx_valid), 32'd1);
            ack_rx();
        end
        @(negedge clk);
        CKP = 1'b0;
        CPH = 1'b0;
        wait_clk(6);

        // Overrun: two frames without rx_ack
        o0 = ovr_cnt;
        tx_write(8'h11);
        spi_frame(8'h11, 8, 1'b1, r);
        check("ovr_first_no_pulse", 32'(ovr_cnt - o0), 32'd0);
        tx_write(8'h22);
        spi_frame(8'h22, 8, 1'b1, r);
        check("ovr_pulse_count", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_rx_data", 32'(rx_data), 32'h22);
        check("ovr_rx_valid", 32'(rx_valid), 32'd1);
        ack_rx();

        // Underrun: empty tx buffer
        u0 = udr_cnt;
        spi_frame(8'h99, 8, 1'b1, r);
        check("udr_pulse_count", 32'(udr_cnt - u0), 32'd1);
        check("udr_miso_word", 32'(r), 32'h00);
        check("udr_rx_data", 32'(rx_data), 32'h99);
        ack_rx();

        // Frame error after 5 bits, then a good frame
        f0 = fe_cnt;
        tx_write(8'h00);
        spi_frame(8'hF0, 5, 1'b1, r);
        check("fe_pulse_count", 32'(fe_cnt - f0), 32'd1);
        check("fe_rx_valid", 32'(rx_valid), 32'd0);
        check("fe_busy", 32'(busy), 32'd0);
        spi_frame(8'h5A, 8, 1'b1, r);
        check("fe_next_rx_data", 32'(rx_data), 32'h5A);
        check("fe_next_rx_valid", 32'(rx_valid), 32'd1);
        check("fe_no_extra", 32'(fe_cnt - f0), 32'd1);

        // Reset mid-frame (rx_valid still set from previous frame)
        tx_write(8'hCF);
        spi_frame(8'h00, 3, 1'b0, r);
        tx_write(8'h42);
        check("mid_busy_before", 32'(busy), 32'd1);
        check("mid_miso_before", 32'(MISO), 32'd1);
        check("mid_tx_ready_before", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_miso", 32'(MISO), 32'd0);
        check("mid_rx_valid", 32'(rx_valid), 32'd0);
        check("mid_rx_data", 32'(rx_data), 32'h00);
        check("mid_pulses", {29'd0, overrun, underrun, frame_err}, 32'd0);
        wait_clk(2);
        CS = 1'b1;
        SCK = 1'b0;
        rst = 1'b1;
        wait_clk(6);

        // Recovery frame after reset
        tx_write(8'h42);
        spi_frame(8'h24, 8, 1'b1, r);
        check("post_rst_rx_data", 32'(rx_data), 32'h24);
        check("post_rst_miso_word", 32'(r), 32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
